// File: rtl/dag_pkg.sv
// Shared definitions for the data address generator: ureg group encodings and register-file sizing.
package dag_pkg;

  localparam int DAG_NUM_REGS = 8;
  localparam int DAG_SEL_W    = 3;

  typedef enum logic [1:0] {
    GRP_I = 2'b00,
    GRP_M = 2'b01,
    GRP_L = 2'b10,
    GRP_B = 2'b11
  } dag_grp_e;

endpackage

// File: rtl/dag_modify.sv
// Combinational index update: I + signed M, optionally wrapped into the circular buffer [B, B+L).
module dag_modify #(
  parameter int DMA_SIZE = 17
) (
  input  logic [DMA_SIZE-1:0] i_val,
  input  logic [DMA_SIZE-1:0] m_val,
  input  logic [DMA_SIZE-1:0] l_val,
  input  logic [DMA_SIZE-1:0] b_val,
  input  logic                circ_en,
  output logic [DMA_SIZE-1:0] mod_add
);

  // Two guard bits keep the sum and B+L exact, so a step below a buffer at 0 is seen as negative.
  localparam int XW = DMA_SIZE + 2;

  logic signed [XW-1:0] sum_x;
  logic signed [XW-1:0] base_x;
  logic signed [XW-1:0] len_x;
  logic signed [XW-1:0] top_x;

  always_comb begin
    sum_x   = signed'({2'b00, i_val}) + signed'({{2{m_val[DMA_SIZE-1]}}, m_val});
    base_x  = signed'({2'b00, b_val});
    len_x   = signed'({2'b00, l_val});
    top_x   = base_x + len_x;
    mod_add = sum_x[DMA_SIZE-1:0];
    if (circ_en && (l_val != '0)) begin
      if (sum_x >= top_x) begin
        mod_add = DMA_SIZE'(sum_x - len_x);
      end else if (sum_x < base_x) begin
        mod_add = DMA_SIZE'(sum_x + len_x);
      end
    end
  end

endmodule

// File: rtl/dag.sv
// Data address generator: 8x I/M/L/B registers, pre/post-modify addressing with circular wrap.
// Define DG_BYPASS_EN to forward same-cycle ureg writes into address generation and ureg reads.
module dag
  import dag_pkg::*;
#(
  parameter int DMA_SIZE = 17,
  parameter int DMD_SIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_dg_en,
  input  logic [2:0]          ps_dg_i,
  input  logic [2:0]          ps_dg_m,
  input  logic                ps_dg_pre,
  input  logic                ps_dg_wrt_en,
  input  logic [4:0]          ps_dg_wrt_add,
  input  logic [DMD_SIZE-1:0] bc_dg_dt,
  input  logic                ps_dg_rd_en,
  input  logic [4:0]          ps_dg_rd_add,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] dg_bc_dt
);

`ifdef DG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DMA_SIZE-1:0] i_reg [DAG_NUM_REGS];
  logic [DMA_SIZE-1:0] m_reg [DAG_NUM_REGS];
  logic [DMA_SIZE-1:0] l_reg [DAG_NUM_REGS];
  logic [DMA_SIZE-1:0] b_reg [DAG_NUM_REGS];
  logic [DMA_SIZE-1:0] i_next [DAG_NUM_REGS];
  logic [DMA_SIZE-1:0] m_next [DAG_NUM_REGS];
  logic [DMA_SIZE-1:0] l_next [DAG_NUM_REGS];
  logic [DMA_SIZE-1:0] b_next [DAG_NUM_REGS];

  logic [DMA_SIZE-1:0] dg_dm_add_reg, dg_dm_add_next;
  logic [DMD_SIZE-1:0] dg_bc_dt_reg, dg_bc_dt_next;

  dag_grp_e             wrt_grp, rd_grp;
  logic [DAG_SEL_W-1:0] wrt_num, rd_num;
  logic [DMA_SIZE-1:0]  wdata_z, wdata_s;

  assign wrt_grp = dag_grp_e'(ps_dg_wrt_add[4:3]);
  assign wrt_num = ps_dg_wrt_add[2:0];
  assign rd_grp  = dag_grp_e'(ps_dg_rd_add[4:3]);
  assign rd_num  = ps_dg_rd_add[2:0];
  assign wdata_z = {{(DMA_SIZE-DMD_SIZE){1'b0}}, bc_dg_dt};
  assign wdata_s = {{(DMA_SIZE-DMD_SIZE){bc_dg_dt[DMD_SIZE-1]}}, bc_dg_dt};

  // Operand selection, with optional forwarding of the write happening this cycle.
  logic fwd_i, fwd_m, fwd_l, fwd_b;
  logic [DMA_SIZE-1:0] i_op, m_op, l_op, b_op, mod_add;

  assign fwd_i = BYPASS && ps_dg_wrt_en && (wrt_grp == GRP_I) && (wrt_num == ps_dg_i);
  assign fwd_m = BYPASS && ps_dg_wrt_en && (wrt_grp == GRP_M) && (wrt_num == ps_dg_m);
  assign fwd_l = BYPASS && ps_dg_wrt_en && (wrt_grp == GRP_L) && (wrt_num == ps_dg_i);
  assign fwd_b = BYPASS && ps_dg_wrt_en && (wrt_grp == GRP_B) && (wrt_num == ps_dg_i);

  assign i_op = fwd_i ? wdata_z : i_reg[ps_dg_i];
  assign m_op = fwd_m ? wdata_s : m_reg[ps_dg_m];
  assign l_op = fwd_l ? wdata_z : l_reg[ps_dg_i];
  assign b_op = fwd_b ? wdata_z : b_reg[ps_dg_i];

  // Pre-modify addresses are linear; only the post-modify index update wraps.
  dag_modify #(
    .DMA_SIZE(DMA_SIZE)
  ) u_modify (
    .i_val  (i_op),
    .m_val  (m_op),
    .l_val  (l_op),
    .b_val  (b_op),
    .circ_en(~ps_dg_pre),
    .mod_add(mod_add)
  );

  assign dg_dm_add_next = !ps_dg_en ? dg_dm_add_reg :
                          ps_dg_pre ? mod_add : i_op;

  generate
    for (genvar gi = 0; gi < DAG_NUM_REGS; gi++) begin : g_reg
      logic wr_hit, upd_hit;
      assign wr_hit  = ps_dg_wrt_en && (wrt_num == DAG_SEL_W'(gi));
      assign upd_hit = ps_dg_en && !ps_dg_pre && (ps_dg_i == DAG_SEL_W'(gi));
      // A ureg write to I takes priority over the post-modify update.
      assign i_next[gi] = (wr_hit && wrt_grp == GRP_I) ? wdata_z :
                          upd_hit                      ? mod_add : i_reg[gi];
      assign m_next[gi] = (wr_hit && wrt_grp == GRP_M) ? wdata_s : m_reg[gi];
      assign l_next[gi] = (wr_hit && wrt_grp == GRP_L) ? wdata_z : l_reg[gi];
      assign b_next[gi] = (wr_hit && wrt_grp == GRP_B) ? wdata_z : b_reg[gi];
    end
  endgenerate

  logic [DMD_SIZE-1:0] rd_val;
  logic                fwd_rd;

  assign fwd_rd = BYPASS && ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add);

  always_comb begin
    rd_val = '0;
    case (rd_grp)
      GRP_I: rd_val = i_reg[rd_num][DMD_SIZE-1:0];
      GRP_M: rd_val = m_reg[rd_num][DMD_SIZE-1:0];
      GRP_L: rd_val = l_reg[rd_num][DMD_SIZE-1:0];
      GRP_B: rd_val = b_reg[rd_num][DMD_SIZE-1:0];
    endcase
    dg_bc_dt_next = dg_bc_dt_reg;
    if (ps_dg_rd_en) begin
      dg_bc_dt_next = fwd_rd ? bc_dg_dt : rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DAG_NUM_REGS; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      dg_dm_add_reg <= '0;
      dg_bc_dt_reg  <= '0;
    end else begin
      for (int k = 0; k < DAG_NUM_REGS; k++) begin
        i_reg[k] <= i_next[k];
        m_reg[k] <= m_next[k];
        l_reg[k] <= l_next[k];
        b_reg[k] <= b_next[k];
      end
      dg_dm_add_reg <= dg_dm_add_next;
      dg_bc_dt_reg  <= dg_bc_dt_next;
    end
  end

  assign dg_dm_add = dg_dm_add_reg;
  assign dg_bc_dt  = dg_bc_dt_reg;

endmodule

// File: doc/dag.md
Name: dag

Overview:
- Data address generator. Sits directly upstream of the data-memory stage and drives its DM address input dg_dm_add.
- Holds 8 index (I), modify (M), length (L) and base (B) registers.
- Produces pre-modified or post-modified addresses with optional circular-buffer wrap.
- Registers are readable and writable as universal registers over the data bus.

Parameters:
- DMA_SIZE, 17, DM address width; width of every I/M/L/B register.
- DMD_SIZE, 16, data-bus width for ureg read/write.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ps_dg_en  input  1  address-generation request from the decoder this cycle.
- ps_dg_i  input  3  index register select (I0-I7).
- ps_dg_m  input  3  modify register select (M0-M7).
- ps_dg_pre  input  1  1 = pre-modify (no update); 0 = post-modify (update I).
- ps_dg_wrt_en  input  1  ureg write enable.
- ps_dg_wrt_add  input  5  [4:3] group (I/M/L/B), [2:0] register number.
- bc_dg_dt  input  DMD_SIZE  ureg write data.
- ps_dg_rd_en  input  1  ureg read enable.
- ps_dg_rd_add  input  5  ureg read address, same encoding as write.
- dg_dm_add  output  DMA_SIZE  registered DM address.
- dg_bc_dt  output  DMD_SIZE  registered ureg read data.

Behaviour:
- Reset: all 32 registers, dg_dm_add and dg_bc_dt go to 0 on the edge with reset=1. Reset overrides every other input, including mid-operation requests.
- Latency: request in cycle N gives dg_dm_add valid in cycle N+1, which is the cycle the sequencer asserts ps_dm_cslt. Back-to-back requests are supported at one per cycle.
- When ps_dg_en=0, dg_dm_add holds its value.
- Pre-modify: dg_dm_add <= I[i]+M[m], computed modulo 2^DMA_SIZE with no circular wrap. I[i] is unchanged.
- Post-modify: dg_dm_add <= I[i]. I[i] <= wrap(I[i]+M[m]).
- wrap(x):
  - L[i]==0: linear, x modulo 2^DMA_SIZE.
  - otherwise, if x >= B[i]+L[i] then x-L[i]; if x < B[i] then x+L[i]; else x.
  - Circular mode requires |M| < L. Behaviour outside that constraint is undefined.
- M is interpreted as two's complement (signed) across DMA_SIZE bits.
- Ureg write:
  - I/L/B take bc_dg_dt zero-extended.
  - M takes bc_dg_dt sign-extended.
  - The write takes effect at the edge.
- Same-cycle ureg write to I[i] and post-modify update of I[i]: the ureg write wins.
- Same-cycle ureg write and address use of the same register: the use sees the old value (unless DG_BYPASS_EN).
- Ureg read: dg_bc_dt <= low DMD_SIZE bits of the addressed register, one cycle later. Reading I[i] in the cycle of its post-modify returns the pre-update value.
- When ps_dg_rd_en=0, dg_bc_dt holds its value.

Optional Feature:
- Macro DG_BYPASS_EN.
- Defined: a ureg write in cycle N is forwarded to any same-cycle address computation or ureg read of that register, so the extended write data replaces the old register value.
- Undefined: no forwarding. The new value is visible from cycle N+1, and the decoder must insert one cycle of separation.

Decomposition:
- Shared package holds:
  - group encodings: GRP_I=2'b00, GRP_M=2'b01, GRP_L=2'b10, GRP_B=2'b11;
  - DAG_NUM_REGS=8;
  - DAG_SEL_W=3.
- One sub-module, dag_modify: combinational I+M with circular wrap against B/L. It returns the modified address and is instantiated once.

Test Plan:
- Reset then ureg read of I3 -> dg_bc_dt=0x0000; dg_dm_add=0x00000.
- Write B0=0x0010, L0=4, I0=0x0013, M0=1; post-modify I0/M0 -> dg_dm_add=0x00013 next cycle; I0 reads back 0x0010.
- Write M1=0xFFFF (-1), I0=0x0010, B0=0x0010, L0=4; post-modify I0/M1 -> dg_dm_add=0x00010; I0 becomes 0x0013.
- L2=0, I2=0x1FFFF (write via two-step or force), M2=1; post-modify -> dg_dm_add=0x1FFFF; I2 becomes 0x00000. Pre-modify I2=0x0020, M2=4 -> dg_dm_add=0x00024; I2 stays 0x0020.
- Same cycle: ureg write I0=0x0050 and post-modify on I0 with M0=1 -> dg_dm_add=old I0; I0=0x0050. With DG_BYPASS_EN -> dg_dm_add=0x00050; I0=0x0050.
- Post-modify request with reset asserted in the same cycle -> I/M/L/B=0, dg_dm_add=0; no update applied.
